adc_readout_packer: RTL

ADC_READOUT_PACKER -- requirements
Module: adc_readout_packer

---
 rtl/tft_readout_pkg.sv | 19 +
 rtl/adc_readout_packer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tft_readout_pkg.sv
// rtl/tft_readout_pkg.sv - shared state encoding, word tags and width for the ADC readout packer
package tft_readout_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] TAG_HDR = 2'b10;
  localparam logic [1:0] TAG_PIX = 2'b00;
  localparam logic [1:0] TAG_TRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WAIT_DATA,
    PIXEL,
    TRAILER,
    DONE
  } state_t;

endpackage

// File: rtl/adc_readout_packer.sv
// rtl/adc_readout_packer.sv - packs ADC FIFO pixels into header/pixel/trailer line packets
module adc_readout_packer
  import tft_readout_pkg::*;
#(
  parameter int PIX_PER_LINE = 16,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [11:0]       lines_per_frame,
  input  logic              abort,
  input  logic [10:0]       fifo_level,
  input  logic [13:0]       fifo_data,
  output logic              fifo_rd,
  output logic              fifo_flush,
  output logic [WORD_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sol,
  output logic              tx_eol,
  output logic              busy,
  output logic              frame_done,
  output logic              err_timeout
);

  localparam int              TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [10:0]     PIX_LAST = 11'(PIX_PER_LINE - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  state_t          state;
  logic [11:0]     lines_m1;
  logic [11:0]     line_cnt;
  logic [10:0]     pix_cnt;
  logic [13:0]     pix_reg;
  logic [13:0]     checksum;
  logic [TO_W-1:0] empty_cnt;
  logic [1:0]      hold_cnt;
  logic            line_err;
  logic            err_q;
  logic            flush_q;

  logic handshake;
  logic fifo_empty;
  logic pop;
  logic timeout_hit;

  assign handshake   = tx_valid && tx_ready;
  assign fifo_empty  = (fifo_level == 11'd0);
  // The FIFO level lags a pop by two cycles, so hold_cnt blocks re-reading a stale level
  assign pop         = (state == WAIT_DATA) && !fifo_empty && (hold_cnt == 2'd0) && !abort;
  assign timeout_hit = (state == WAIT_DATA) && fifo_empty && (empty_cnt == TO_LAST);

  assign fifo_rd     = pop;
  assign fifo_flush  = flush_q;
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);
  assign err_timeout = err_q;

  always_comb begin
    tx_valid = 1'b0;
    tx_sol   = 1'b0;
    tx_eol   = 1'b0;
    tx_data  = '0;
    case (state)
      HEADER: begin
        tx_valid = 1'b1;
        tx_sol   = 1'b1;
        tx_data  = {TAG_HDR, 2'b00, line_cnt};
      end
      PIXEL: begin
        tx_valid = 1'b1;
        tx_data  = {TAG_PIX, pix_reg};
      end
      TRAILER: begin
        tx_valid = 1'b1;
        tx_eol   = 1'b1;
        tx_data  = {TAG_TRL, line_err, checksum[12:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lines_m1  <= '0;
      line_cnt  <= '0;
      pix_cnt   <= '0;
      pix_reg   <= '0;
      checksum  <= '0;
      empty_cnt <= '0;
      hold_cnt  <= '0;
      line_err  <= 1'b0;
      err_q     <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      flush_q <= abort;
      if (hold_cnt != 2'd0) hold_cnt <= hold_cnt - 2'd1;

      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              state     <= HEADER;
              lines_m1  <= (lines_per_frame == 12'd0) ? 12'd0 : lines_per_frame - 12'd1;
              line_cnt  <= '0;
              pix_cnt   <= '0;
              checksum  <= '0;
              empty_cnt <= '0;
              line_err  <= 1'b0;
              err_q     <= 1'b0;
            end
          end
          HEADER: begin
            if (handshake) state <= WAIT_DATA;
          end
          WAIT_DATA: begin
            if (pop) begin
              pix_reg   <= fifo_data;
              hold_cnt  <= 2'd2;
              empty_cnt <= '0;
              state     <= PIXEL;
            end else if (timeout_hit) begin
              err_q    <= 1'b1;
              line_err <= 1'b1;
              state    <= TRAILER;
            end else if (fifo_empty) begin
              empty_cnt <= empty_cnt + TO_W'(1);
            end
          end
          PIXEL: begin
            if (handshake) begin
              checksum <= checksum ^ pix_reg;
              if (pix_cnt == PIX_LAST) begin
                state <= TRAILER;
              end else begin
                pix_cnt <= pix_cnt + 11'd1;
                state   <= WAIT_DATA;
              end
            end
          end
          TRAILER: begin
            // A timed-out line ends the whole frame
            if (handshake) begin
              if (line_err || (line_cnt == lines_m1)) begin
                state <= DONE;
              end else begin
                line_cnt <= line_cnt + 12'd1;
                pix_cnt  <= '0;
                checksum <= '0;
                state    <= HEADER;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
